// File: rtl/sqrt_pkg.sv
//------------------------------------------------------------------------------
// Module  : sqrt_pkg
// Brief   : Shared types, width helpers and a reference square root.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

  function automatic int root_w(input int data_w);
    return data_w / 2;
  endfunction

  function automatic int rem_w(input int data_w);
    return data_w / 2 + 1;
  endfunction

  // Bitwise trial-squaring search, deliberately unlike the digit recurrence.
  function automatic logic [31:0] sqrt_ref(input logic [63:0] x);
    logic [31:0] r;
    logic [31:0] c;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      c = r | (32'd1 << i);
      if (64'(c) * 64'(c) <= x) r = c;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sqrt_result_reg.sv
//------------------------------------------------------------------------------
// Module  : sqrt_result_reg
// Brief   : Root/remainder holding register with synchronous clear and load.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sqrt_result_reg #(
  parameter int ROOT_W = 8,
  parameter int REM_W  = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [ROOT_W-1:0] root_d,
  input  logic [REM_W-1:0]  rem_d,
  output logic [ROOT_W-1:0] root,
  output logic [REM_W-1:0]  rem
);

  logic [ROOT_W-1:0] root_q;
  logic [REM_W-1:0]  rem_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      root_q <= '0;
      rem_q  <= '0;
    end else if (load) begin
      root_q <= root_d;
      rem_q  <= rem_d;
    end
  end

  assign root = root_q;
  assign rem  = rem_q;

endmodule

`default_nettype wire

// File: rtl/sqrt_iter_core.sv
//------------------------------------------------------------------------------
// Module  : sqrt_iter_core
// Brief   : Iterative integer square root, one root bit per clock.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sqrt_iter_core
  import sqrt_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ROOT_W = root_w(DATA_W),
  parameter int REM_W  = rem_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              start,
  input  logic [DATA_W-1:0] radicand,
  output logic [ROOT_W-1:0] root,
  output logic [REM_W-1:0]  rem,
  output logic              busy,
  output logic              done
);

  localparam int              PW       = REM_W + 1;
  localparam int              CNT_W    = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROOT_W - 1);

  generate
    if ((DATA_W % 2) != 0 || DATA_W < 4 || ROOT_W != DATA_W / 2 || REM_W != DATA_W / 2 + 1)
    begin : g_bad_params
      $error("sqrt_iter_core: DATA_W must be even and >= 4; ROOT_W/REM_W are derived");
    end
  endgenerate

  sqrt_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [PW-1:0]     p_q, p_d;
  logic [ROOT_W-1:0] y_q, y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_res;

  // Digit step evaluated two bits wider than P so nothing is lost before the compare.
  logic [PW+1:0]     p_shift, trial, p_new;
  logic [ROOT_W-1:0] y_new;
  logic              fits;

  always_comb begin
    p_shift = {p_q, x_q[DATA_W-1 -: 2]};
    trial   = (PW+2)'({y_q, 2'b01});
    fits    = (p_shift >= trial);
    p_new   = fits ? (p_shift - trial) : p_shift;
    y_new   = {y_q[ROOT_W-2:0], fits};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    p_d      = p_q;
    y_d      = y_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load_res = 1'b0;
    if (init) begin
      state_d = IDLE;
      cnt_d   = '0;
      x_d     = '0;
      p_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = CNT_LOAD;
            x_d     = radicand;
            p_d     = '0;
            y_d     = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          x_d = {x_q[DATA_W-3:0], 2'b00};
          p_d = p_new[PW-1:0];
          y_d = y_new;
          if (cnt_q == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            load_res = 1'b1;
          end else begin
            cnt_d  = cnt_q - 1'b1;
            busy_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      p_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      p_q     <= p_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sqrt_result_reg #(
    .ROOT_W (ROOT_W),
    .REM_W  (REM_W)
  ) u_result (
    .clk    (clk),
    .clr    (rst | init),
    .load   (load_res),
    .root_d (y_new),
    .rem_d  (p_new[REM_W-1:0]),
    .root   (root),
    .rem    (rem)
  );

  assign busy = busy_q;
  assign done = done_q;

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));
  a_rem_bound: assert property (@(posedge clk) disable iff (rst) done_q |-> (rem <= {root, 1'b0}));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN) |-> (p_new[PW+1:PW] == 2'b00));
  a_p_top_clear: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN && cnt_q == '0) |-> !p_new[PW-1]);

endmodule

`default_nettype wire
